vending_ctrl: RTL and testbench

//   Parametrised beverage vending controller, successor to the fixed-price 2-coin FSM.
//   - Accumulates half-unit and one-unit coins into a credit register; vends when credit >= PRICE.
//   - Returns change or a cancelled credit serially, one half-unit coin pulse per cycle.
//   - Sits between the debounced/pulsed coin acceptor and the dispenser/coin-hopper drivers.
//

---
 rtl/vending_ctrl.sv | 151 +++++++++++++++
 tb/tb_vending_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl.sv
// ---------------------------------------------------------------------------------------------
// vending_ctrl: parametrised beverage vending controller.
//
// Coins are summed into a credit register in half-units. A vend starts the cycle after the coin
// that brings credit to PRICE or more. Any change, and any cancelled credit, is paid back one
// half-unit coin pulse per cycle.
//
// Optional feature: define VEND_TIMEOUT_EN to refund credit left idle in ACCUM for TIMEOUT
// cycles. Without it, tmo_o is tied low and credit is held indefinitely.
//
// Ports
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset
//   half_i      half-unit coin, 1-cycle pulse
//   one_i       one-unit coin, 1-cycle pulse
//   cancel_i    refund request, 1-cycle pulse
//   bev_o       dispense beverage, 1-cycle pulse (Moore)
//   chg_half_o  eject one half-unit coin, one pulse per coin (Moore)
//   coin_rej_o  coin refused this cycle (combinational on the coin inputs)
//   busy_o      high in VEND or CHANGE (Moore)
//   credit_o    current credit in half-units
//   tmo_o       timeout refund started, 1-cycle pulse
// ---------------------------------------------------------------------------------------------
module vending_ctrl #(
   parameter int unsigned PRICE    = 4,
   parameter int unsigned CREDIT_W = 4,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                half_i,
   input  logic                one_i,
   input  logic                cancel_i,
   output logic                bev_o,
   output logic                chg_half_o,
   output logic                coin_rej_o,
   output logic                busy_o,
   output logic [CREDIT_W-1:0] credit_o,
   output logic                tmo_o
);

   typedef enum logic [1:0] {StIdle, StAccum, StVend, StChange} state_e;

   localparam logic [CREDIT_W:0]   PriceWide = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W-1:0] PriceNarrow = CREDIT_W'(PRICE);

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;

   logic                coin;
   logic                coin_accept;
   logic                tmo_hit;
   logic [CREDIT_W:0]   coin_val;
   logic [CREDIT_W:0]   credit_sum;

   assign coin = half_i | one_i;

   // one wins when both coins arrive together; the half coin is silently discarded.
   assign coin_val   = {{(CREDIT_W-1){1'b0}}, one_i, half_i & ~one_i};
   // One bit wider than the register so the PRICE comparison never sees a wrapped sum.
   assign credit_sum = {1'b0, credit_q} + coin_val;

`ifdef VEND_TIMEOUT_EN
   localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

   // A coin or a cancel in the terminal cycle takes priority over the timeout.
   assign tmo_hit = (state_q == StAccum) && !coin && !cancel_i && (tmo_cnt_q == TmoLast);

   always_comb begin
      tmo_cnt_d = '0;
      if (state_q == StAccum && state_d == StAccum && !coin_accept) begin
         tmo_cnt_d = tmo_cnt_q + TmoW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign tmo_hit        = 1'b0;
`endif

   // State and credit registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         credit_q <= '0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
      end
   end

   // Next-state and credit update.
   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      coin_accept = 1'b0;
      unique case (state_q)
         StIdle, StAccum: begin
            // cancel only matters once there is credit to refund.
            if (state_q == StAccum && cancel_i) begin
               state_d = StChange;
            end else if (coin) begin
               coin_accept = 1'b1;
               credit_d    = credit_sum[CREDIT_W-1:0];
               state_d     = (credit_sum >= PriceWide) ? StVend : StAccum;
            end else if (tmo_hit) begin
               state_d = StChange;
            end
         end
         StVend: begin
            credit_d = credit_q - PriceNarrow;
            state_d  = (credit_q > PriceNarrow) ? StChange : StIdle;
         end
         StChange: begin
            if (credit_q != '0) begin
               credit_d = credit_q - CREDIT_W'(1);
            end
            if (credit_q <= CREDIT_W'(1)) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d  = StIdle;
            credit_d = '0;
         end
      endcase
   end

   // Outputs.
   always_comb begin
      bev_o      = (state_q == StVend);
      chg_half_o = (state_q == StChange);
      busy_o     = (state_q == StVend) || (state_q == StChange);
      // Refused when busy, or when a cancel in ACCUM beats the coin.
      coin_rej_o = coin && (busy_o || (state_q == StAccum && cancel_i));
      credit_o   = credit_q;
      tmo_o      = tmo_hit;
   end

endmodule

// File: tb/tb_vending_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_vending_ctrl: directed self-checking bench for vending_ctrl with PRICE=4, CREDIT_W=4,
// TIMEOUT=8. Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------------------------
module tb_vending_ctrl;

   logic       clk;
   logic       rst_n;
   logic       half;
   logic       one;
   logic       cancel;
   logic       bev;
   logic       chg_half;
   logic       coin_rej;
   logic       busy;
   logic [3:0] credit;
   logic       tmo;

   int checks   = 0;
   int failures = 0;

   vending_ctrl #(
      .PRICE   (4),
      .CREDIT_W(4),
      .TIMEOUT (8)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .half_i    (half),
      .one_i     (one),
      .cancel_i  (cancel),
      .bev_o     (bev),
      .chg_half_o(chg_half),
      .coin_rej_o(coin_rej),
      .busy_o    (busy),
      .credit_o  (credit),
      .tmo_o     (tmo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      half   = 1'b0;
      one    = 1'b0;
      cancel = 1'b0;
      #12;
      checks++;
      if ({bev, chg_half, coin_rej, busy, credit, tmo} !== 9'b0) begin
         failures++;
         $display("FAIL reset_in: outs=%b required=%b",
                  {bev, chg_half, coin_rej, busy, credit, tmo}, 9'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if ({bev, chg_half, coin_rej, busy, credit, tmo} !== 9'b0) begin
         failures++;
         $display("FAIL reset_out: outs=%b required=%b",
                  {bev, chg_half, coin_rej, busy, credit, tmo}, 9'b0);
      end
   endtask

   task automatic test_four_halves();
      for (int i = 1; i <= 3; i++) begin
         half = 1'b1;
         tick();
         half = 1'b0;
         checks++;
         if ({bev, busy, credit} !== {1'b0, 1'b0, 4'(i)}) begin
            failures++;
            $display("FAIL halves_credit%0d: bev,busy,credit=%b required=%b", i,
                     {bev, busy, credit}, {1'b0, 1'b0, 4'(i)});
         end
         tick();
      end
      half = 1'b1;
      tick();
      half = 1'b0;
      checks++;
      if ({bev, chg_half, busy, credit} !== {1'b1, 1'b0, 1'b1, 4'd4}) begin
         failures++;
         $display("FAIL halves_vend: bev,chg,busy,credit=%b required=%b",
                  {bev, chg_half, busy, credit}, {1'b1, 1'b0, 1'b1, 4'd4});
      end
      tick();
      checks++;
      if ({bev, chg_half, busy, credit} !== 7'b0) begin
         failures++;
         $display("FAIL halves_idle: bev,chg,busy,credit=%b required=%b",
                  {bev, chg_half, busy, credit}, 7'b0);
      end
   endtask

   task automatic test_change_one();
      half = 1'b1;
      tick();
      half = 1'b0;
      one  = 1'b1;
      tick();
      checks++;
      if (credit !== 4'd3) begin
         failures++;
         $display("FAIL chg1_credit3: credit=%0d required=3", credit);
      end
      tick();
      one = 1'b0;
      checks++;
      if ({bev, chg_half, busy, credit} !== {1'b1, 1'b0, 1'b1, 4'd5}) begin
         failures++;
         $display("FAIL chg1_vend: bev,chg,busy,credit=%b required=%b",
                  {bev, chg_half, busy, credit}, {1'b1, 1'b0, 1'b1, 4'd5});
      end
      tick();
      checks++;
      if ({bev, chg_half, busy, credit} !== {1'b0, 1'b1, 1'b1, 4'd1}) begin
         failures++;
         $display("FAIL chg1_pulse: bev,chg,busy,credit=%b required=%b",
                  {bev, chg_half, busy, credit}, {1'b0, 1'b1, 1'b1, 4'd1});
      end
      tick();
      checks++;
      if ({bev, chg_half, busy, credit} !== 7'b0) begin
         failures++;
         $display("FAIL chg1_idle: bev,chg,busy,credit=%b required=%b",
                  {bev, chg_half, busy, credit}, 7'b0);
      end
   endtask

   task automatic test_cancel_refund();
      int pulses = 0;
      int busys  = 0;
      int bevs   = 0;
      half = 1'b1;
      tick();
      half = 1'b0;
      one  = 1'b1;
      tick();
      one    = 1'b0;
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      for (int j = 0; j < 6; j++) begin
         pulses += int'(chg_half);
         busys  += int'(busy);
         bevs   += int'(bev);
         tick();
      end
      checks++;
      if (pulses != 3 || busys != 3 || bevs != 0) begin
         failures++;
         $display("FAIL cancel_counts: pulses=%0d busy=%0d bev=%0d required=3/3/0",
                  pulses, busys, bevs);
      end
      checks++;
      if (credit !== 4'd0) begin
         failures++;
         $display("FAIL cancel_credit: credit=%0d required=0", credit);
      end
   endtask

   task automatic test_coin_reject();
      // Scenario with change of 1, coins offered while busy.
      half = 1'b1;
      tick();
      half = 1'b0;
      one  = 1'b1;
      tick();
      tick();
      #1;
      checks++;
      if ({bev, coin_rej} !== 2'b11) begin
         failures++;
         $display("FAIL rej_vend: bev,coin_rej=%b required=11", {bev, coin_rej});
      end
      tick();
      one  = 1'b0;
      half = 1'b1;
      #1;
      checks++;
      if ({chg_half, coin_rej, credit} !== {1'b1, 1'b1, 4'd1}) begin
         failures++;
         $display("FAIL rej_change: chg,coin_rej,credit=%b required=%b",
                  {chg_half, coin_rej, credit}, {1'b1, 1'b1, 4'd1});
      end
      tick();
      half = 1'b0;
      checks++;
      if ({chg_half, busy, credit} !== 6'b0) begin
         failures++;
         $display("FAIL rej_after: chg,busy,credit=%b required=%b",
                  {chg_half, busy, credit}, 6'b0);
      end
      // Both coins together in IDLE.
      half = 1'b1;
      one  = 1'b1;
      #1;
      checks++;
      if (coin_rej !== 1'b0) begin
         failures++;
         $display("FAIL both_rej: coin_rej=%b required=0", coin_rej);
      end
      tick();
      half = 1'b0;
      one  = 1'b0;
      checks++;
      if ({busy, credit} !== {1'b0, 4'd2}) begin
         failures++;
         $display("FAIL both_credit: busy,credit=%b required=%b", {busy, credit}, {1'b0, 4'd2});
      end
      // cancel beats a coin in ACCUM.
      cancel = 1'b1;
      half   = 1'b1;
      #1;
      checks++;
      if (coin_rej !== 1'b1) begin
         failures++;
         $display("FAIL cancel_coin_rej: coin_rej=%b required=1", coin_rej);
      end
      tick();
      cancel = 1'b0;
      half   = 1'b0;
      checks++;
      if ({chg_half, busy, credit} !== {1'b1, 1'b1, 4'd2}) begin
         failures++;
         $display("FAIL cancel_coin_chg: chg,busy,credit=%b required=%b",
                  {chg_half, busy, credit}, {1'b1, 1'b1, 4'd2});
      end
      tick();
      tick();
      checks++;
      if ({chg_half, busy, credit} !== 6'b0) begin
         failures++;
         $display("FAIL cancel_coin_idle: chg,busy,credit=%b required=%b",
                  {chg_half, busy, credit}, 6'b0);
      end
      // cancel alone in IDLE is ignored; cancel with a coin in IDLE accepts the coin.
      cancel = 1'b1;
      tick();
      checks++;
      if ({chg_half, busy, credit} !== 6'b0) begin
         failures++;
         $display("FAIL idle_cancel: chg,busy,credit=%b required=%b",
                  {chg_half, busy, credit}, 6'b0);
      end
      half = 1'b1;
      tick();
      half   = 1'b0;
      cancel = 1'b0;
      checks++;
      if ({chg_half, busy, credit} !== {1'b0, 1'b0, 4'd1}) begin
         failures++;
         $display("FAIL idle_cancel_coin: chg,busy,credit=%b required=%b",
                  {chg_half, busy, credit}, {1'b0, 1'b0, 4'd1});
      end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_change();
      half = 1'b1;
      tick();
      half = 1'b0;
      one  = 1'b1;
      tick();
      one    = 1'b0;
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      tick();
      checks++;
      if ({chg_half, credit} !== {1'b1, 4'd2}) begin
         failures++;
         $display("FAIL rst_mid_pre: chg,credit=%b required=%b", {chg_half, credit},
                  {1'b1, 4'd2});
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bev, chg_half, busy, credit} !== 7'b0) begin
         failures++;
         $display("FAIL rst_mid_abort: bev,chg,busy,credit=%b required=%b",
                  {bev, chg_half, busy, credit}, 7'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if ({bev, chg_half, busy, credit} !== 7'b0) begin
         failures++;
         $display("FAIL rst_mid_after: bev,chg,busy,credit=%b required=%b",
                  {bev, chg_half, busy, credit}, 7'b0);
      end
   endtask

   task automatic test_timeout();
`ifdef VEND_TIMEOUT_EN
      int early = 0;
      one = 1'b1;
      tick();
      one = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         early += int'(tmo);
         tick();
      end
      checks++;
      if (early != 0 || {tmo, busy, credit} !== {1'b1, 1'b0, 4'd2}) begin
         failures++;
         $display("FAIL tmo_fire: early=%0d tmo,busy,credit=%b required=0 %b", early,
                  {tmo, busy, credit}, {1'b1, 1'b0, 4'd2});
      end
      tick();
      checks++;
      if ({tmo, chg_half, credit} !== {1'b0, 1'b1, 4'd2}) begin
         failures++;
         $display("FAIL tmo_chg1: tmo,chg,credit=%b required=%b", {tmo, chg_half, credit},
                  {1'b0, 1'b1, 4'd2});
      end
      tick();
      tick();
      checks++;
      if ({chg_half, busy, credit} !== 6'b0) begin
         failures++;
         $display("FAIL tmo_idle: chg,busy,credit=%b required=%b", {chg_half, busy, credit},
                  6'b0);
      end
      // Coin on the terminal cycle suppresses the timeout and restarts the count.
      half = 1'b1;
      tick();
      half = 1'b0;
      repeat (7) tick();
      half = 1'b1;
      #1;
      checks++;
      if (tmo !== 1'b0) begin
         failures++;
         $display("FAIL tmo_suppress: tmo=%b required=0", tmo);
      end
      tick();
      half = 1'b0;
      repeat (7) tick();
      checks++;
      if ({tmo, credit} !== {1'b1, 4'd2}) begin
         failures++;
         $display("FAIL tmo_restart: tmo,credit=%b required=%b", {tmo, credit}, {1'b1, 4'd2});
      end
      repeat (3) tick();
`else
      int tmos  = 0;
      int busys = 0;
      half = 1'b1;
      tick();
      half = 1'b0;
      for (int k = 0; k < 300; k++) begin
         tmos  += int'(tmo);
         busys += int'(busy);
         tick();
      end
      checks++;
      if (tmos != 0 || busys != 0 || credit !== 4'd1) begin
         failures++;
         $display("FAIL hold_credit: tmo=%0d busy=%0d credit=%0d required=0/0/1", tmos, busys,
                  credit);
      end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      tick();
`endif
      checks++;
      if ({chg_half, busy, credit} !== 6'b0) begin
         failures++;
         $display("FAIL tmo_end_idle: chg,busy,credit=%b required=%b", {chg_half, busy, credit},
                  6'b0);
      end
   endtask

   initial begin
      test_reset();
      test_four_halves();
      test_change_one();
      test_cancel_refund();
      test_coin_reject();
      test_reset_mid_change();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
